// File: rtl/user_mode_select.sv
// Mode-word selector: after a pause press, waits for the board toggles to hold steady and
// latches them as the user mode, falling back to DEFAULT_MODE (with fault) on timeout.
module user_mode_select #(
    parameter int                NUM_SW         = 2,
    parameter int                STABLE_CYC     = 4,
    parameter int                TIMEOUT_CYC    = 64,
    parameter logic [NUM_SW-1:0] DEFAULT_MODE   = '0,
    parameter bit                ALLOW_RESELECT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] toggle,
    input  logic              pause,
    input  logic              reselect,
    output logic [NUM_SW-1:0] mode,
    output logic              valid,
    output logic              mode_strobe,
    output logic              busy,
    output logic              fault
);

    localparam int STAB_W = $clog2(STABLE_CYC + 1);
    localparam int TO_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit TO_EN  = (TIMEOUT_CYC != 0);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYC - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              state;
    logic [NUM_SW-1:0]   snap;
    logic [STAB_W-1:0]   stab_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic                pause_q;

    logic                pause_rise;
    logic                sample_match;
    logic                stable_done;
    logic                timed_out;

    assign pause_rise   = pause & ~pause_q;
    assign sample_match = (toggle == snap);
    assign stable_done  = sample_match && (stab_cnt == STAB_LAST);
    assign timed_out    = TO_EN && (to_cnt == TO_LAST);

    // Stable completion is checked before the timeout so a clean latch wins a tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_WAIT;
            mode        <= '0;
            valid       <= 1'b0;
            mode_strobe <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
            snap        <= '0;
            stab_cnt    <= '0;
            to_cnt      <= '0;
            pause_q     <= 1'b0;
        end else begin
            pause_q     <= pause;
            mode_strobe <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (pause_rise) begin
                        state    <= S_SETTLE;
                        snap     <= toggle;
                        stab_cnt <= '0;
                        to_cnt   <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (TO_EN) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                    if (stable_done) begin
                        mode        <= snap;
                        valid       <= 1'b1;
                        fault       <= 1'b0;
                        mode_strobe <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_DONE;
                    end else if (timed_out) begin
                        mode        <= DEFAULT_MODE;
                        valid       <= 1'b1;
                        fault       <= 1'b1;
                        mode_strobe <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_DONE;
                    end else if (!sample_match) begin
                        snap     <= toggle;
                        stab_cnt <= '0;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // The old mode word stays visible but is disqualified until the next capture.
                    if (ALLOW_RESELECT && reselect) begin
                        valid <= 1'b0;
                        fault <= 1'b0;
                        state <= S_WAIT;
                    end
                end
                default: begin
                    state <= S_WAIT;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_user_mode_select.sv
// Scoreboard bench for user_mode_select: the stimulus side predicts each capture outcome from
// the toggle sequence, a negedge monitor checks every mode_strobe against the queue.
module tb_user_mode_select;

    localparam int         STB = 4;
    localparam int         TO  = 16;
    localparam logic [1:0] DEF = 2'b01;

    typedef logic [1:0] seq_t [0:TO];

    typedef struct {
        logic [1:0] mode;
        logic       fault;
        int         cyc;
    } expect_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] toggle = 2'b00;
    logic       pause = 1'b0;
    logic       reselect = 1'b0;
    logic [1:0] mode;
    logic       valid;
    logic       modeStrobe;
    logic       busy;
    logic       fault;

    logic [1:0] toggleB = 2'b00;
    logic       pauseB = 1'b0;
    logic       reselectB = 1'b0;
    logic [1:0] modeB;
    logic       validB;
    logic       strobeB;
    logic       busyB;
    logic       faultB;

    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    expect_t    sb[$];

    user_mode_select #(
        .NUM_SW(2), .STABLE_CYC(STB), .TIMEOUT_CYC(TO), .DEFAULT_MODE(DEF), .ALLOW_RESELECT(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .toggle(toggle), .pause(pause), .reselect(reselect),
        .mode(mode), .valid(valid), .mode_strobe(modeStrobe), .busy(busy), .fault(fault)
    );

    user_mode_select #(
        .NUM_SW(2), .STABLE_CYC(STB), .TIMEOUT_CYC(TO), .DEFAULT_MODE(DEF), .ALLOW_RESELECT(1'b0)
    ) dutNoResel (
        .clk(clk), .rst(rst), .toggle(toggleB), .pause(pauseB), .reselect(reselectB),
        .mode(modeB), .valid(validB), .mode_strobe(strobeB), .busy(busyB), .fault(faultB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Outcome of a capture: the first settle edge k whose sample closes a run of STB+1 equal
    // samples latches that sample; if no such run appears by edge TO the default is used.
    function automatic void predict(input seq_t s, output int k, output logic [1:0] m,
                                    output logic f);
        bit same;
        k = -1;
        for (int j = STB; j <= TO && k < 0; j++) begin
            same = 1'b1;
            for (int i = j - STB; i < j; i++) begin
                if (s[i] != s[j]) same = 1'b0;
            end
            if (same) k = j;
        end
        if (k < 0) begin
            k = TO;
            m = DEF;
            f = 1'b1;
        end else begin
            m = s[k];
            f = 1'b0;
        end
    endfunction

    // Caller guarantees the DUT is in its waiting state and pause was low at the last edge.
    task automatic applyStimulus(input seq_t s, output logic [1:0] latched);
        int         k;
        logic [1:0] m;
        logic       f;
        expect_t    e;
        predict(s, k, m, f);
        latched = m;
        toggle = s[0];
        pause  = 1'b1;
        @(posedge clk); #1;
        e.mode  = m;
        e.fault = f;
        e.cyc   = cyc + k;
        sb.push_back(e);
        for (int j = 1; j <= k; j++) begin
            checkOutput("busy during settle", busy, 1);
            checkOutput("valid during settle", valid, 0);
            toggle = s[j];
            @(posedge clk); #1;
        end
        checkOutput("busy after decision", busy, 0);
        checkOutput("valid after decision", valid, 1);
        checkOutput("mode after decision", mode, m);
        checkOutput("fault after decision", fault, f);
        toggle = 2'($urandom_range(0, 3));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("mode held in done", mode, m);
    endtask

    task automatic doReselect(input logic [1:0] oldMode);
        reselect = 1'b1;
        @(posedge clk); #1;
        reselect = 1'b0;
        checkOutput("valid after reselect", valid, 0);
        checkOutput("fault after reselect", fault, 0);
        checkOutput("busy after reselect", busy, 0);
        checkOutput("mode kept after reselect", mode, oldMode);
    endtask

    task automatic pauseLow();
        pause = 1'b0;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (modeStrobe) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected mode_strobe", 1, 0);
            end else begin
                expect_t e;
                e = sb.pop_front();
                checkOutput("strobe cycle", cyc, e.cyc);
                checkOutput("strobe mode", mode, e.mode);
                checkOutput("strobe fault", fault, e.fault);
                checkOutput("strobe valid", valid, 1);
            end
        end
    end

    initial begin
        seq_t       s;
        logic [1:0] m;
        logic [1:0] v;
        int         n;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset mode", mode, 0);
        checkOutput("reset valid", valid, 0);
        checkOutput("reset strobe", modeStrobe, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset fault", fault, 0);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] clean capture");
        for (int i = 0; i <= TO; i++) s[i] = 2'b10;
        applyStimulus(s, m);

        $display("[TB] pause pulse while done");
        pauseLow();
        pause = 1'b1;
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("done ignores pause mode", mode, 2'b10);
        checkOutput("done ignores pause valid", valid, 1);
        checkOutput("done ignores pause busy", busy, 0);

        $display("[TB] reselect with pause held high");
        doReselect(2'b10);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("held pause no capture busy", busy, 0);
        checkOutput("held pause no capture valid", valid, 0);
        pauseLow();

        $display("[TB] bounce capture");
        s[0] = 2'b01; s[1] = 2'b00; s[2] = 2'b01; s[3] = 2'b00;
        for (int i = 4; i <= TO; i++) s[i] = 2'b01;
        applyStimulus(s, m);
        doReselect(m);
        pauseLow();

        $display("[TB] timeout capture");
        for (int i = 0; i <= TO; i++) s[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
        applyStimulus(s, m);
        doReselect(m);
        pauseLow();

        $display("[TB] reselect then new capture of 11");
        for (int i = 0; i <= TO; i++) s[i] = 2'b11;
        applyStimulus(s, m);
        doReselect(m);
        pauseLow();

        $display("[TB] randomized captures");
        for (int t = 0; t < 12; t++) begin
            v = 2'($urandom_range(0, 3));
            n = $urandom_range(0, 8);
            case ($urandom_range(0, 2))
                0: for (int i = 0; i <= TO; i++) s[i] = 2'($urandom_range(0, 3));
                1: for (int i = 0; i <= TO; i++) s[i] = (i < n) ? 2'($urandom_range(0, 3)) : v;
                default: for (int i = 0; i <= TO; i++) s[i] = v;
            endcase
            applyStimulus(s, m);
            doReselect(m);
            pauseLow();
        end

        $display("[TB] reset during settle");
        toggle = 2'b10;
        pause  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b0;
        #1;
        checkOutput("async reset mode", mode, 0);
        checkOutput("async reset valid", valid, 0);
        checkOutput("async reset strobe", modeStrobe, 0);
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset fault", fault, 0);
        pause = 1'b0;
        #10 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("idle after reset busy", busy, 0);
        checkOutput("idle after reset valid", valid, 0);

        $display("[TB] reselect disabled instance");
        toggleB = 2'b11;
        pauseB  = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("noresel valid", validB, 1);
        checkOutput("noresel mode", modeB, 2'b11);
        checkOutput("noresel fault", faultB, 0);
        reselectB = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("noresel valid held", validB, 1);
            checkOutput("noresel mode held", modeB, 2'b11);
        end
        reselectB = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
